rv_ctrl_fsm: RTL and testbench
==============================

Name:
rv_ctrl_fsm

Overview:
- Multi-cycle fetch/decode/control sequencer for the RISC-V core; it is the producer side of the execute-stage interface.
- Fetches an instruction over a ready-handshake instruction port and decodes it into the ALU op code, operand selects and immediate that the execute stage consumes.
- Sequences memory access and register writeback, then updates the PC from the execute result.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  current PC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- ALUop_o  out  5  op code to execute stage.
- ALUSrc1  out  1  operand 1 select: 1 = PC, 0 = rs1 data.
- ALUSrc2  out  1  operand 2 select: 1 = Imm, 0 = rs2 data.
- Imm  out  32  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register indices from the instruction register (IR).
- ALUOut  in  32  execute-stage result.
- br_eq  in  1  rs1 data == rs2 data, from register-file compare.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store.
- dmem_ack  in  1  data access complete.
- RegWrite  out  1  register-file write strobe.
- WBSel  out  2  writeback source: 0 = ALUOut, 1 = memory, 2 = PC+4.
- illegal  out  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Reset (async, rst_n = 0):
  - state = FETCH, PC = RESET_PC, IR = 0.
  - Every output is 0 except imem_addr, which is RESET_PC.
  - All outputs take these values immediately, mid-transaction included.
- FETCH:
  - imem_req = 1, held until imem_ready.
  - On a cycle with imem_ready = 1: IR <= imem_rdata, go to DECODE.
  - imem_ready in the same cycle as the request is allowed; that gives a 1-cycle fetch.
- Control outputs (ALUop_o, ALUSrc1/2, Imm, rs1/rs2/rd, WBSel) are decoded from IR.
  - Valid from DECODE until the instruction leaves its last state.
  - Forced to 0 during FETCH.
- Supported instructions (all others are illegal):
  - add 01101, sub 01110, sll 01000, xor 00110, srl 01001, or 00101, and 00100.
    - Opcode 0110011, exact funct3/funct7 match.
    - ALUSrc1 = 0, ALUSrc2 = 0.
  - addi 01100: opcode 0010011, funct3 000; ALUSrc2 = 1, I-immediate.
  - lw 10100: opcode 0000011, funct3 010; ALUSrc2 = 1, I-immediate.
  - sw 10101: opcode 0100011, funct3 010; ALUSrc2 = 1, S-immediate.
  - beq 10001: opcode 1100011, funct3 000; ALUSrc1 = 1, ALUSrc2 = 1, B-immediate.
  - jalr 10100: opcode 1100111, funct3 000; ALUSrc2 = 1, I-immediate.
- State sequence:
  - DECODE always lasts 1 cycle, then EXEC.
  - EXEC lasts 1 cycle:
    - ALU/jalr: go to WB.
    - lw/sw: go to MEM.
    - beq: PC <= br_eq ? ALUOut : PC+4, then go to FETCH.
  - MEM: dmem_req = 1 and dmem_we = (sw), held until dmem_ack.
    - On ack, lw goes to WB.
    - On ack, sw does PC <= PC+4 and goes to FETCH.
  - WB lasts 1 cycle:
    - RegWrite = (rd != 0).
    - PC <= jalr ? {ALUOut[31:1], 1'b0} : PC+4.
    - Then go to FETCH.
    - WBSel: 2 for jalr, 1 for lw, 0 otherwise.
- Illegal instruction:
  - In DECODE, illegal = 1 for that cycle only.
  - Next state is FETCH with PC <= PC+4; no memory access, no register write.
- Latency with zero-wait handshakes:
  - ALU/jalr: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - illegal: 2 cycles.
- Arithmetic: PC+4 is 32-bit and wraps (0xFFFF_FFFC -> 0). jalr target bit 1 is not checked.
- br_eq and ALUOut are sampled only in EXEC (and in WB for jalr); they are ignored in all other states.

Test Plan:
- Reset, imem_ready = 1, instruction 0x00500093 (addi x1,x0,5):
  - DECODE shows ALUop_o = 01100, ALUSrc1 = 0, ALUSrc2 = 1, Imm = 5, rd = 1.
  - WB shows RegWrite = 1, WBSel = 0.
  - Next imem_addr = 4, four cycles after the first fetch.
- 0x00208463 (beq x1,x2,+8) at PC = 0x10, ALUOut = 0x18:
  - br_eq = 1 -> ALUop_o = 10001, ALUSrc1/2 = 1, Imm = 8, next imem_addr = 0x18.
  - br_eq = 0 -> next imem_addr = 0x14.
- 0x0040A183 (lw x3,4(x1)) with dmem_ack 3 cycles late:
  - dmem_req held high with dmem_we = 0 until ack.
  - Then one WB cycle with RegWrite = 1, WBSel = 1, rd = 3.
- 0x0020A423 (sw x2,8(x1)):
  - Imm = 8, ALUop_o = 10101, dmem_we = 1.
  - RegWrite never asserts; PC += 4.
- 0x000080E7 (jalr x1,0(x1)) with ALUOut = 0x101:
  - RegWrite = 1, WBSel = 2, next imem_addr = 0x100.
  - Then 0x00000000 -> illegal pulses for exactly 1 cycle, no writes, PC += 4.
- Assert rst_n = 0 during MEM with dmem_req = 1:
  - dmem_req drops before the next clock edge.
  - After release, imem_req = 1 with imem_addr = RESET_PC.

Source files
------------

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle fetch/decode/control sequencer for the RISC-V core.
// Drives the execute stage with decoded controls and sequences memory, writeback and PC update.
module rv_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  ALUop_o,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [31:0] Imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  input  logic [31:0] ALUOut,
  input  logic        br_eq,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        RegWrite,
  output logic [1:0]  WBSel,
  output logic        illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {K_ILL, K_ALU, K_LW, K_SW, K_BEQ, K_JALR} kind_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STOR = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] OP_ADD  = 5'b01101;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_LW   = 5'b10100;
  localparam logic [4:0] OP_SW   = 5'b10101;
  localparam logic [4:0] OP_BEQ  = 5'b10001;
  localparam logic [4:0] OP_JALR = 5'b10100;

  state_t             state, state_nxt;
  logic        [31:0] pc, pc_nxt, pc_plus4;
  logic        [31:0] ir, ir_nxt;

  kind_t              kind;
  logic        [4:0]  dec_op;
  logic               dec_src1, dec_src2;
  logic signed [31:0] dec_imm;
  logic        [1:0]  dec_wbsel;
  logic               ctl_en;

  function automatic logic signed [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Instruction decode from IR
  always_comb begin
    kind      = K_ILL;
    dec_op    = '0;
    dec_src1  = 1'b0;
    dec_src2  = 1'b0;
    dec_imm   = '0;
    case (ir[6:0])
      OPC_R: begin
        if (ir[31:25] == 7'b0000000) begin
          kind = K_ALU;
          case (ir[14:12])
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            3'b111:  dec_op = OP_AND;
            default: kind   = K_ILL;
          endcase
        end else if (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000) begin
          kind   = K_ALU;
          dec_op = OP_SUB;
        end
      end
      OPC_IMM: if (ir[14:12] == 3'b000) begin
        kind     = K_ALU;
        dec_op   = OP_ADDI;
        dec_src2 = 1'b1;
        dec_imm  = imm_i(ir);
      end
      OPC_LOAD: if (ir[14:12] == 3'b010) begin
        kind     = K_LW;
        dec_op   = OP_LW;
        dec_src2 = 1'b1;
        dec_imm  = imm_i(ir);
      end
      OPC_STOR: if (ir[14:12] == 3'b010) begin
        kind     = K_SW;
        dec_op   = OP_SW;
        dec_src2 = 1'b1;
        dec_imm  = imm_s(ir);
      end
      OPC_BR: if (ir[14:12] == 3'b000) begin
        kind     = K_BEQ;
        dec_op   = OP_BEQ;
        dec_src1 = 1'b1;
        dec_src2 = 1'b1;
        dec_imm  = imm_b(ir);
      end
      OPC_JALR: if (ir[14:12] == 3'b000) begin
        kind     = K_JALR;
        dec_op   = OP_JALR;
        dec_src2 = 1'b1;
        dec_imm  = imm_i(ir);
      end
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    case (kind)
      K_JALR:  dec_wbsel = 2'd2;
      K_LW:    dec_wbsel = 2'd1;
      default: dec_wbsel = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state, PC update and handshake strobes
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    ctl_en    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        // the async reset holds state in FETCH, so the request is masked explicitly
        imem_req = rst_n;
        if (imem_ready) begin
          ir_nxt    = imem_rdata;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl_en = 1'b1;
        if (kind == K_ILL) begin
          illegal   = 1'b1;
          pc_nxt    = pc_plus4;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ctl_en = 1'b1;
        case (kind)
          K_LW, K_SW: state_nxt = S_MEM;
          K_BEQ: begin
            pc_nxt    = br_eq ? ALUOut : pc_plus4;
            state_nxt = S_FETCH;
          end
          K_ALU, K_JALR: state_nxt = S_WB;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        ctl_en   = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (kind == K_SW);
        if (dmem_ack) begin
          if (kind == K_SW) begin
            pc_nxt    = pc_plus4;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        ctl_en    = 1'b1;
        RegWrite  = (ir[11:7] != 5'd0);
        pc_nxt    = (kind == K_JALR) ? {ALUOut[31:1], 1'b0} : pc_plus4;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign ALUop_o = ctl_en ? dec_op    : '0;
  assign ALUSrc1 = ctl_en & dec_src1;
  assign ALUSrc2 = ctl_en & dec_src2;
  assign Imm     = ctl_en ? dec_imm   : '0;
  assign rs1     = ctl_en ? ir[19:15] : '0;
  assign rs2     = ctl_en ? ir[24:20] : '0;
  assign rd      = ctl_en ? ir[11:7]  : '0;
  assign WBSel   = ctl_en ? dec_wbsel : '0;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Scoreboard bench for rv_ctrl_fsm: driver pushes expected per-instruction behaviour,
// a negedge monitor pops and compares controls, pulse counts, latency and fetch PC.
module tb_rv_ctrl_fsm;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [4:0]  ALUop_o;
  logic        ALUSrc1, ALUSrc2;
  logic [31:0] Imm;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ALUOut = '0;
  logic        br_eq = 1'b0;
  logic        dmem_req, dmem_we;
  logic        dmem_ack = 1'b0;
  logic        RegWrite;
  logic [1:0]  WBSel;
  logic        illegal;

  always #5 clk = ~clk;

  rv_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ALUop_o(ALUop_o), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .Imm(Imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .ALUOut(ALUOut), .br_eq(br_eq),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .RegWrite(RegWrite), .WBSel(WBSel), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic        s1, s2;
    logic [31:0] imm;
    logic [4:0]  r1, r2, rdx;
    logic [1:0]  wb;
    bit          ill, mem, we, wr;
    int          md;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  op;
    int          kind;
  } pat_t;

  pat_t        pats[12];
  exp_t        expq[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;
  bit          have_cur = 0, mon_en = 0, flush_req = 0, flush_done = 0;
  int          nf, n_ill, n_wr, n_mem;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference: instruction semantics computed from the ISA rules
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w, input logic [31:0] alu,
                                 input logic br, input int md, output logic [31:0] npc);
    exp_t e;
    int   k = -1;
    int   iv, sv, bv;
    e = '{default: 0};
    for (int i = 0; i < 12; i++)
      if ((w & pats[i].mask) == pats[i].match) begin
        k    = pats[i].kind;
        e.op = pats[i].op;
      end
    iv = $signed(w[31:20]);
    sv = $signed({w[31:25], w[11:7]});
    bv = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    e.pc = pc; e.r1 = w[19:15]; e.r2 = w[24:20]; e.rdx = w[11:7]; e.md = md;
    npc = pc + 32'd4;
    case (k)
      0: begin e.wr = (w[11:7] != 0); e.lat = 3; end
      1: begin e.s2 = 1; e.imm = iv; e.wr = (w[11:7] != 0); e.lat = 3; end
      2: begin e.s2 = 1; e.imm = iv; e.mem = 1; e.wb = 1; e.wr = (w[11:7] != 0); e.lat = 4 + md; end
      3: begin e.s2 = 1; e.imm = sv; e.mem = 1; e.we = 1; e.lat = 3 + md; end
      4: begin e.s1 = 1; e.s2 = 1; e.imm = bv; e.lat = 2; npc = br ? alu : pc + 32'd4; end
      5: begin e.s2 = 1; e.imm = iv; e.wb = 2; e.wr = (w[11:7] != 0); e.lat = 3; npc = alu & ~32'd1; end
      default: begin e.ill = 1; e.op = 0; e.lat = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [2:0] mf3(input logic [2:0] good);
    return ($urandom_range(0, 3) == 0) ? 3'($urandom) : good;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [11:0] im;
    logic [6:0]  f7;
    a  = 5'($urandom);
    b  = 5'($urandom);
    d  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    im = 12'($urandom);
    f7 = ($urandom_range(0, 3) == 0) ? 7'b0100000 : 7'b0000000;
    case ($urandom_range(0, 8))
      0, 1:    return {f7, b, a, 3'($urandom), d, 7'b0110011};
      2:       return {im, a, mf3(3'b000), d, 7'b0010011};
      3:       return {im, a, mf3(3'b010), d, 7'b0000011};
      4:       return {im[11:5], b, a, mf3(3'b010), im[4:0], 7'b0100011};
      5:       return {im[11], im[9:4], b, a, mf3(3'b000), im[3:0], im[10], 7'b1100011};
      6:       return {im, a, mf3(3'b000), d, 7'b1100111};
      7:       return $urandom;
      default: return {im, a, 3'b000, d, 7'b0010011};
    endcase
  endfunction

  // Driver: precondition is posedge+1 with the DUT in FETCH
  task automatic issue(input logic [31:0] w, input int fd, input int md,
                       input logic [31:0] alu, input logic br);
    exp_t        e;
    logic [31:0] npc;
    int          n, waited;
    e = model(mpc, w, alu, br, md, npc);
    expq.push_back(e);
    mpc = npc;
    repeat (fd) begin
      imem_ready = 0; imem_rdata = $urandom; ALUOut = $urandom; br_eq = 1'($urandom);
      @(posedge clk); #1;
    end
    imem_ready = 1; imem_rdata = w; ALUOut = alu; br_eq = br; dmem_ack = 0;
    @(posedge clk); #1;
    imem_ready = 0; imem_rdata = $urandom;
    n = 0; waited = 0;
    while (!imem_req) begin
      if (dmem_req) begin
        dmem_ack = (waited >= md);
        waited++;
      end else begin
        dmem_ack = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL instr_timeout actual=%0d required<=100 cycles", n);
        dmem_ack = 0;
        return;
      end
    end
    dmem_ack = 0;
  endtask

  task automatic flush();
    int n = 0;
    flush_done = 0;
    flush_req  = 1;
    while (!flush_done && n < 20) begin @(posedge clk); #1; n++; end
    if (!flush_done) begin
      checks++; errors++;
      $display("FAIL flush_timeout actual=0 required=1");
    end
    flush_req = 0;
  endtask

  function automatic void finalize();
    chk("latency", 64'(nf), 64'(cur.lat));
    chk("illegal_pulses", 64'(n_ill), 64'(cur.ill));
    chk("regwrite_pulses", 64'(n_wr), 64'(cur.wr));
    chk("mem_cycles", 64'(n_mem), cur.mem ? 64'(cur.md + 1) : 64'd0);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_req) begin
        chk("fetch_idle", {ALUop_o, ALUSrc1, ALUSrc2, Imm, rs1, rs2, rd, WBSel,
                           RegWrite, dmem_req, dmem_we, illegal}, 64'd0);
        if (flush_req) begin
          if (have_cur) finalize();
          have_cur   = 0;
          flush_done = 1;
        end else if (imem_ready) begin
          if (have_cur) finalize();
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch actual=%0h required=none", imem_addr);
            have_cur = 0;
          end else begin
            cur = expq.pop_front();
            have_cur = 1;
            chk("fetch_pc", imem_addr, cur.pc);
            nf = 0; n_ill = 0; n_wr = 0; n_mem = 0;
          end
        end
      end else if (have_cur) begin
        nf++;
        chk("controls", {ALUop_o, ALUSrc1, ALUSrc2, Imm, rs1, rs2, rd, WBSel},
                        {cur.op, cur.s1, cur.s2, cur.imm, cur.r1, cur.r2, cur.rdx, cur.wb});
        if (illegal)  n_ill++;
        if (RegWrite) n_wr++;
        if (dmem_req) begin
          n_mem++;
          chk("dmem_we", dmem_we, cur.we);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pats[0]  = '{32'hFE00707F, 32'h00000033, 5'b01101, 0};
    pats[1]  = '{32'hFE00707F, 32'h40000033, 5'b01110, 0};
    pats[2]  = '{32'hFE00707F, 32'h00001033, 5'b01000, 0};
    pats[3]  = '{32'hFE00707F, 32'h00004033, 5'b00110, 0};
    pats[4]  = '{32'hFE00707F, 32'h00005033, 5'b01001, 0};
    pats[5]  = '{32'hFE00707F, 32'h00006033, 5'b00101, 0};
    pats[6]  = '{32'hFE00707F, 32'h00007033, 5'b00100, 0};
    pats[7]  = '{32'h0000707F, 32'h00000013, 5'b01100, 1};
    pats[8]  = '{32'h0000707F, 32'h00002003, 5'b10100, 2};
    pats[9]  = '{32'h0000707F, 32'h00002023, 5'b10101, 3};
    pats[10] = '{32'h0000707F, 32'h00000063, 5'b10001, 4};
    pats[11] = '{32'h0000707F, 32'h00000067, 5'b10100, 5};

    #12;
    chk("reset_outputs", {imem_req, ALUop_o, ALUSrc1, ALUSrc2, Imm, rs1, rs2, rd,
                          dmem_req, dmem_we, RegWrite, WBSel, illegal}, 64'd0);
    chk("reset_pc", imem_addr, RST_PC);
    @(posedge clk); #1;
    rst_n = 1;
    mpc = RST_PC;
    mon_en = 1;
    #1;
    chk("fetch_after_reset", {imem_req, imem_addr}, {1'b1, RST_PC});

    issue(32'h00500093, 0, 0, 32'h0, 0);
    repeat (3) issue(32'h00500093, 1, 0, 32'h0, 0);
    issue(32'h00208463, 0, 0, 32'h18, 1);
    issue(32'h00208463, 1, 0, 32'h18, 0);
    issue(32'h0040A183, 0, 3, 32'h0, 0);
    issue(32'h0020A423, 2, 0, 32'h0, 0);
    issue(32'h000080E7, 0, 0, 32'h101, 0);
    issue(32'h00000000, 0, 0, 32'h0, 0);
    issue(32'h000080E7, 0, 0, 32'hFFFF_FFFD, 1);
    issue(32'h00500093, 0, 0, 32'h0, 0);
    issue(32'h00500093, 0, 0, 32'h0, 0);

    for (int i = 0; i < 300; i++)
      issue(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'($urandom));
    flush();
    chk("queue_empty", 64'(expq.size()), 64'd0);
    mon_en = 0;

    // asynchronous reset in the middle of a data access
    imem_ready = 1; imem_rdata = 32'h0040A183; dmem_ack = 0;
    @(posedge clk); #1;
    imem_ready = 0;
    n = 0;
    while (!dmem_req && n < 10) begin @(posedge clk); #1; n++; end
    chk("mid_mem_req", dmem_req, 1'b1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("async_reset_outputs", {imem_req, ALUop_o, ALUSrc1, ALUSrc2, Imm, rs1, rs2, rd,
                                dmem_req, dmem_we, RegWrite, WBSel, illegal}, 64'd0);
    chk("async_reset_pc", imem_addr, RST_PC);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("restart_fetch", {imem_req, imem_addr}, {1'b1, RST_PC});
    mpc = RST_PC;
    mon_en = 1;
    issue(32'h00500093, 0, 0, 32'h0, 0);
    issue(32'h0020A423, 1, 1, 32'h0, 0);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
